// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line traffic onto one memory port.
// The winning request is latched at grant and held until mem_resp.
module cache_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_W     = 256,
    parameter bit          D_PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                last_d_q, last_d_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                d_req;
    logic                gnt_i;
    logic                gnt_d;

    assign d_req = d_pmem_read | d_pmem_write;

    // State and latched transaction registers; last grant resets to D
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Arbitration in IDLE, completion tracking while serving
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        gnt_i    = 1'b0;
        gnt_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d = d_req &&
                        (!i_pmem_read || D_PRIORITY || !last_d_q);
                gnt_i = i_pmem_read && !gnt_d;
                if (gnt_d) begin
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                    addr_d   = d_pmem_address;
                    wdata_d  = d_pmem_wdata;
                    wr_d     = d_pmem_write;
                end else if (gnt_i) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                    addr_d   = i_pmem_address;
                    wr_d     = 1'b0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory strobes and responses follow the registered state only
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        mem_address  = addr_q;
        mem_wdata    = wdata_q;
        i_pmem_rdata = mem_rdata;
        d_pmem_rdata = mem_rdata;
        if (state_q == SERVE_I) begin
            mem_read    = 1'b1;
            i_pmem_resp = mem_resp;
        end
        if (state_q == SERVE_D) begin
            mem_read    = !wr_q;
            mem_write   = wr_q;
            d_pmem_resp = mem_resp;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter, round-robin and D-priority
// instances share one stimulus stream.
module tb_cache_arbiter;

    logic           clk;
    logic           rst;
    logic           i_read;
    logic [31:0]    i_addr;
    logic           d_read;
    logic           d_write;
    logic [31:0]    d_addr;
    logic [255:0]   d_wdata;
    logic [255:0]   m_rdata;
    logic           m_resp;

    logic [255:0]   rr_i_rdata, rr_d_rdata, rr_wdata;
    logic           rr_i_resp, rr_d_resp, rr_rd, rr_wr;
    logic [31:0]    rr_addr;
    logic [255:0]   dp_i_rdata, dp_d_rdata, dp_wdata;
    logic           dp_i_resp, dp_d_resp, dp_rd, dp_wr;
    logic [31:0]    dp_addr;

    int n_chk;
    int n_fail;
    int d_pulses;

    cache_arbiter #(.ADDR_W(32), .LINE_W(256), .D_PRIORITY(1'b0)) u_rr (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_read), .i_pmem_address(i_addr),
        .i_pmem_rdata(rr_i_rdata), .i_pmem_resp(rr_i_resp),
        .d_pmem_read(d_read), .d_pmem_write(d_write),
        .d_pmem_address(d_addr), .d_pmem_wdata(d_wdata),
        .d_pmem_rdata(rr_d_rdata), .d_pmem_resp(rr_d_resp),
        .mem_read(rr_rd), .mem_write(rr_wr),
        .mem_address(rr_addr), .mem_wdata(rr_wdata),
        .mem_rdata(m_rdata), .mem_resp(m_resp)
    );

    cache_arbiter #(.ADDR_W(32), .LINE_W(256), .D_PRIORITY(1'b1)) u_dp (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_read), .i_pmem_address(i_addr),
        .i_pmem_rdata(dp_i_rdata), .i_pmem_resp(dp_i_resp),
        .d_pmem_read(d_read), .d_pmem_write(d_write),
        .d_pmem_address(d_addr), .d_pmem_wdata(d_wdata),
        .d_pmem_rdata(dp_d_rdata), .d_pmem_resp(dp_d_resp),
        .mem_read(dp_rd), .mem_write(dp_wr),
        .mem_address(dp_addr), .mem_wdata(dp_wdata),
        .mem_rdata(m_rdata), .mem_resp(m_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count D responses seen by the round-robin instance at each edge
    initial d_pulses = 0;
    always @(posedge clk) if (rr_d_resp) d_pulses = d_pulses + 1;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_rd", rr_rd, 1'b0);
        check("rst_wr", rr_wr, 1'b0);
        check("rst_addr", rr_addr, 32'h0);
        check("rst_wdata", rr_wdata, 256'h0);
        check("rst_iresp", rr_i_resp, 1'b0);
        check("rst_dresp", rr_d_resp, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int p0;
        n_chk   = 0;
        n_fail  = 0;
        rst     = 1'b0;
        i_read  = 1'b0;
        i_addr  = '0;
        d_read  = 1'b0;
        d_write = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_rdata = '0;
        m_resp  = 1'b0;
        #2;
        do_reset();

        // Scenario 1: lone D read, response in the 4th serve cycle
        p0 = d_pulses;
        d_read = 1'b1;
        d_addr = 32'h0000_1040;
        tick();
        check("s1_rd_c1", rr_rd, 1'b1);
        check("s1_addr", rr_addr, 32'h0000_1040);
        tick();
        check("s1_rd_c2", rr_rd, 1'b1);
        tick();
        check("s1_rd_c3", rr_rd, 1'b1);
        tick();
        m_resp  = 1'b1;
        m_rdata = {32{8'hA5}};
        #1;
        check("s1_rd_c4", rr_rd, 1'b1);
        check("s1_dresp", rr_d_resp, 1'b1);
        check("s1_drdata", rr_d_rdata, {32{8'hA5}});
        check("s1_iresp", rr_i_resp, 1'b0);
        tick();
        m_resp = 1'b0;
        d_read = 1'b0;
        #1;
        check("s1_rel_rd", rr_rd, 1'b0);
        check("s1_rel_dresp", rr_d_resp, 1'b0);
        tick();
        check("s1_pulses", d_pulses - p0, 1);

        // Scenario 2: write-back (read+write high, write wins), then read
        p0 = d_pulses;
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h0000_2000;
        d_wdata = {8{32'hDEAD_BEEF}};
        tick();
        check("s2_wr", rr_wr, 1'b1);
        check("s2_rd", rr_rd, 1'b0);
        check("s2_addr", rr_addr, 32'h0000_2000);
        check("s2_wdata", rr_wdata, {8{32'hDEAD_BEEF}});
        d_wdata = '0;
        m_resp  = 1'b1;
        #1;
        check("s2_wdata_hold", rr_wdata, {8{32'hDEAD_BEEF}});
        check("s2_wresp", rr_d_resp, 1'b1);
        tick();
        m_resp  = 1'b0;
        d_write = 1'b0;
        d_addr  = 32'h0000_3000;
        #1;
        check("s2_rel_wr", rr_wr, 1'b0);
        check("s2_rel_rd", rr_rd, 1'b0);
        tick();
        check("s2_idle_rd", rr_rd, 1'b0);
        tick();
        check("s2_rd2", rr_rd, 1'b1);
        check("s2_addr2", rr_addr, 32'h0000_3000);
        m_resp = 1'b1;
        #1;
        check("s2_rresp", rr_d_resp, 1'b1);
        tick();
        m_resp = 1'b0;
        d_read = 1'b0;
        tick();
        check("s2_pulses", d_pulses - p0, 2);

        // Scenarios 3/4: repeated ties from reset
        do_reset();
        i_read = 1'b1;
        i_addr = 32'h0000_0100;
        d_read = 1'b1;
        d_addr = 32'h0000_0200;
        tick();
        check("s3_t1_addr", rr_addr, 32'h0000_0100);
        check("s4_t1_addr", dp_addr, 32'h0000_0200);
        m_resp = 1'b1;
        #1;
        check("s3_t1_iresp", rr_i_resp, 1'b1);
        check("s3_t1_dresp", rr_d_resp, 1'b0);
        check("s4_t1_dresp", dp_d_resp, 1'b1);
        check("s4_t1_iresp", dp_i_resp, 1'b0);
        tick();
        m_resp = 1'b0;
        #1;
        check("s3_rel_rd", rr_rd, 1'b0);
        tick();
        check("s3_idle_rd", rr_rd, 1'b0);
        tick();
        check("s3_t2_addr", rr_addr, 32'h0000_0200);
        check("s4_t2_addr", dp_addr, 32'h0000_0200);
        m_resp = 1'b1;
        #1;
        check("s3_t2_dresp", rr_d_resp, 1'b1);
        tick();
        m_resp = 1'b0;
        tick();
        tick();
        check("s3_t3_addr", rr_addr, 32'h0000_0100);
        check("s4_t3_addr", dp_addr, 32'h0000_0200);
        m_resp = 1'b1;
        #1;
        check("s3_t3_iresp", rr_i_resp, 1'b1);
        tick();
        m_resp = 1'b0;
        i_read = 1'b0;
        d_read = 1'b0;
        tick();

        // Scenario 5: input change mid-serve, stray resp when idle
        d_read = 1'b1;
        d_addr = 32'h0000_4000;
        tick();
        d_addr = 32'hFFFF_FFC0;
        tick();
        check("s5_addr_hold", rr_addr, 32'h0000_4000);
        m_resp = 1'b1;
        #1;
        check("s5_dresp", rr_d_resp, 1'b1);
        tick();
        d_read = 1'b0;
        #1;
        check("s5_rel_dresp", rr_d_resp, 1'b0);
        tick();
        check("s5_idle_dresp", rr_d_resp, 1'b0);
        check("s5_idle_iresp", rr_i_resp, 1'b0);
        check("s5_idle_rd", rr_rd, 1'b0);
        m_resp = 1'b0;
        tick();

        // Scenario 6: reset in the middle of an I transaction
        i_read = 1'b1;
        i_addr = 32'h0000_0500;
        tick();
        check("s6_rd", rr_rd, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("s6_rst_rd", rr_rd, 1'b0);
        check("s6_rst_addr", rr_addr, 32'h0);
        m_resp = 1'b1;
        #1;
        check("s6_rst_iresp", rr_i_resp, 1'b0);
        m_resp = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("s6_regrant_rd", rr_rd, 1'b1);
        check("s6_regrant_addr", rr_addr, 32'h0000_0500);
        m_resp = 1'b1;
        #1;
        check("s6_iresp", rr_i_resp, 1'b1);
        tick();
        m_resp = 1'b0;
        i_read = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
